router_pkt_register: RTL and testbench
======================================

// Module: router_pkt_register
// PURPOSE
//  Ingress packet register/controller for the 1x3 router; sits directly upstream of the three router FIFOs.
//  Accepts header/payload/parity bytes from the source with a valid/ready handshake.
//  Decodes the destination and drives one-hot write_enb, lfd_state and dout into the selected FIFO.
//  Computes running parity and flags mismatches; drops packets with an invalid address or an aborted destination.
// PARAMETERS
//  DATA_WIDTH  8  byte width; header = {payload_len[DATA_WIDTH-3:0], addr[1:0]}
//  NUM_PORTS   3  number of FIFOs; addr >= NUM_PORTS is invalid (addr 2'b11 with the default)
// PORTS
//  clk         in   1   single clock, all state updates on posedge
//  reset       in   1   synchronous, active-high
//  pkt_valid   in   1   source byte valid on data_in
//  data_in     in   8   header, then payload_len payload bytes, then 1 parity byte
//  ready       out  1   byte accepted at posedge when pkt_valid && ready
//  fifo_full   in   3   full flags of FIFO0..2
//  soft_reset  in   3   per-FIFO soft reset (timeout) from the synchroniser
//  dout        out  8   byte to FIFOs
//  write_enb   out  3   one-hot FIFO write enable
//  lfd_state   out  1   high with write_enb when dout is the header byte
//  busy        out  1   packet in progress (state != IDLE)
//  parity_err  out  1   one-cycle pulse: received parity != computed parity
//  pkt_drop    out  1   one-cycle pulse: packet discarded (bad address or soft_reset abort)
// BEHAVIOUR
//  Reset: state=IDLE; dout=0, write_enb=0, lfd_state=0, parity_err=0, pkt_drop=0; rem=0, sel=0, par=0.
//  Handshake: accept = pkt_valid && ready.
//   ready = (state!=DROP_WAIT) && !(|write_enb && fifo_full[sel]); ready is combinational from state and inputs.
//   pkt_valid must stay high for every byte; the source holds data_in while ready=0.
//  Output stage: one register deep, latency 1.
//   An accepted byte appears on dout with write_enb[sel]=1 in the following cycle.
//   If fifo_full[sel]=1 while write_enb is high: hold dout/write_enb/lfd_state unchanged and stall (skid hold).
//   Release the hold on the first cycle fifo_full[sel]=0; the FIFO consumes the byte at that edge.
//   With no new accept, write_enb clears after the byte is consumed.
//  FSM states:
//   IDLE: on accept, latch sel=addr, rem=payload_len, par=data_in.
//     addr valid: register header, lfd_state=1, go PAYLOAD (or PARITY if len=0).
//     addr invalid: no write, go DROP with rem=len+1.
//   PAYLOAD: on accept, write byte, par^=data_in, rem--. When rem reaches 0, go PARITY.
//   PARITY: on accept, write the parity byte.
//     Next cycle: parity_err=(data_in!=par) as a pulse. Go IDLE.
//   DROP: ready=1, accept and discard bytes, rem-- (no writes). When the last byte is taken, pulse pkt_drop and go IDLE.
//   DROP_WAIT: internal one-cycle state, entered only on a soft_reset abort; see below.
//  Abort: soft_reset[sel]=1 in PAYLOAD/PARITY:
//   clear write_enb (pending byte lost), enter DROP for the remaining rem+1 bytes, pulse pkt_drop at the end.
//   A byte accepted in the same cycle counts as discarded.
//  soft_reset on a non-selected FIFO: ignored.
//  Back-to-back packets: a header may be accepted in IDLE in the cycle after the parity byte is accepted.
//  busy=1 in every state except IDLE; the upstream source must not start a new packet while busy.
//  Lengths: payload_len 0..63; the FIFO receives len+2 bytes per good packet.
//  Simultaneous events: reset overrides everything; the skid hold takes priority over accept.
// TESTING
//  1. Reset: reset=1 for 2 cycles -> all outputs 0, ready=1, busy=0.
//  2. Good packet: hdr 8'h39 (len 14, addr 1), 14 random bytes, correct parity, fifo_full=0.
//     Expected: write_enb=3'b010 for 16 consecutive cycles, lfd_state only on the first, parity_err=0, busy drops after parity.
//  3. Bad parity: same packet with parity^8'h01 -> parity_err pulses once, 1 cycle after parity accept; all 16 bytes still written.
//  4. Full stall: addr 0, len 4. Raise fifo_full[0] for 3 cycles after the 2nd payload write.
//     Expected: dout/write_enb held, ready=0 for those cycles, no byte lost or duplicated (6 writes total).
//  5. Invalid address: hdr 8'h0B (len 2, addr 3) + 3 bytes -> write_enb stays 0, ready=1 throughout, pkt_drop pulses after the 4th byte.
//  6. Abort: addr 2, len 10, soft_reset[2]=1 after payload byte 5.
//     Expected: write_enb clears the next cycle, the remaining bytes are consumed, pkt_drop=1; the next packet writes normally.

Source files
------------

// File: rtl/router_pkt_if.sv
// Source-side handshake and FIFO-side write bus of the router ingress register.
// master = packet source / FIFO bank, slave = router_pkt_register.
interface router_pkt_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 3
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic [NUM_PORTS-1:0]  fifo_full;
    logic [NUM_PORTS-1:0]  soft_reset;
    logic [DATA_WIDTH-1:0] dout;
    logic [NUM_PORTS-1:0]  write_enb;
    logic                  lfd_state;
    logic                  busy;
    logic                  parity_err;
    logic                  pkt_drop;

    modport master (
        output pkt_valid, data_in, fifo_full, soft_reset,
        input  ready, dout, write_enb, lfd_state, busy, parity_err, pkt_drop
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, soft_reset,
        output ready, dout, write_enb, lfd_state, busy, parity_err, pkt_drop
    );
endinterface

// File: rtl/router_pkt_register.sv
// Ingress packet register for the 1x3 router: decodes the header, writes bytes one-hot
// into the selected FIFO through a one-deep skid register, checks parity, drops bad packets.
//
//  state       | meaning
//  IDLE        | waiting for a header byte
//  PAYLOAD     | forwarding payload bytes, rem counts what is left
//  PARITY      | next accepted byte is the parity byte
//  DROP        | discarding rem bytes (bad address or abort), no writes
//  DROP_WAIT   | one stalled cycle after a soft_reset abort
module router_pkt_register #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    router_pkt_if.slave      bus
);
    localparam int LEN_W = DATA_WIDTH - 2;
    localparam int REM_W = LEN_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PAYLOAD   = 3'd1;
    localparam logic [2:0] S_PARITY    = 3'd2;
    localparam logic [2:0] S_DROP      = 3'd3;
    localparam logic [2:0] S_DROP_WAIT = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [NUM_PORTS-1:0]  wen_q, wen_d;
    logic                  lfd_q, lfd_d;
    logic                  perr_q, perr_d;
    logic                  drop_q, drop_d;

    logic [3:0]       full_ext, srst_ext;
    logic [1:0]       hdr_addr;
    logic [LEN_W-1:0] hdr_len;
    logic             addr_ok;
    logic             hold, ready, accept;
    logic             wr, wr_hdr, abort;
    logic [1:0]       wr_sel;

    assign full_ext = 4'(bus.fifo_full);
    assign srst_ext = 4'(bus.soft_reset);
    assign hdr_addr = bus.data_in[1:0];
    assign hdr_len  = bus.data_in[DATA_WIDTH-1:2];
    assign addr_ok  = (32'(hdr_addr) < NUM_PORTS);

    // A byte sitting in the output register for a full FIFO blocks everything upstream.
    assign hold   = (|wen_q) && full_ext[sel_q];
    assign ready  = (state_q != S_DROP_WAIT) && !hold;
    assign accept = bus.pkt_valid && ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        par_d   = par_q;
        perr_d  = 1'b0;
        drop_d  = 1'b0;
        wr      = 1'b0;
        wr_hdr  = 1'b0;
        wr_sel  = sel_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d = hdr_addr;
                    par_d = bus.data_in;
                    if (addr_ok) begin
                        wr      = 1'b1;
                        wr_hdr  = 1'b1;
                        wr_sel  = hdr_addr;
                        rem_d   = REM_W'(hdr_len);
                        state_d = (hdr_len == '0) ? S_PARITY : S_PAYLOAD;
                    end else begin
                        rem_d   = REM_W'(hdr_len) + REM_W'(1);
                        state_d = S_DROP;
                    end
                end
            end
            S_PAYLOAD, S_PARITY: begin
                if (srst_ext[sel_q]) begin
                    // a byte taken in the abort cycle is already one of the discarded ones
                    abort   = 1'b1;
                    rem_d   = accept ? rem_q : rem_q + REM_W'(1);
                    state_d = S_DROP_WAIT;
                end else if (accept) begin
                    wr = 1'b1;
                    if (state_q == S_PAYLOAD) begin
                        par_d = par_q ^ bus.data_in;
                        rem_d = rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) state_d = S_PARITY;
                    end else begin
                        perr_d  = (bus.data_in != par_q);
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (accept) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP_WAIT: begin
                if (rem_q == '0) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        wen_d  = wen_q;
        lfd_d  = lfd_q;
        if (abort) begin
            wen_d = '0;
            lfd_d = 1'b0;
        end else if (!hold) begin
            if (wr) begin
                dout_d = bus.data_in;
                wen_d  = NUM_PORTS'(1) << wr_sel;
                lfd_d  = wr_hdr;
            end else begin
                wen_d = '0;
                lfd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            rem_q   <= '0;
            par_q   <= '0;
            dout_q  <= '0;
            wen_q   <= '0;
            lfd_q   <= 1'b0;
            perr_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            wen_q   <= wen_d;
            lfd_q   <= lfd_d;
            perr_q  <= perr_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.ready      = ready;
    assign bus.dout       = dout_q;
    assign bus.write_enb  = wen_q;
    assign bus.lfd_state  = lfd_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.parity_err = perr_q;
    assign bus.pkt_drop   = drop_q;
endmodule

// File: tb/tb_router_pkt_register.sv
// Bench for router_pkt_register: packet-level reference model checked every cycle,
// directed scenarios with hand-computed counts, then randomized packets with stalls and aborts.
module tb_router_pkt_register;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_pkt_if bus ();
    router_pkt_register dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks bytes left in the current packet rather than a state machine.
    logic [2:0] m_wen;
    logic [7:0] m_dout, m_par;
    logic       m_lfd, m_perr, m_drop, m_busy, m_bad, m_wait;
    logic [1:0] m_port;
    int         m_left;

    always @(posedge clk) begin : model
        logic hold, rdy, acc, abort;
        logic [7:0] d;
        if (reset) begin
            m_wen = 0; m_dout = 0; m_par = 0; m_lfd = 0; m_perr = 0; m_drop = 0;
            m_busy = 0; m_bad = 0; m_wait = 0; m_port = 0; m_left = 0;
        end else begin
            d     = bus.data_in;
            hold  = |(m_wen & bus.fifo_full);
            rdy   = !m_wait && !hold;
            acc   = bus.pkt_valid && rdy;
            abort = 1'b0;
            if (m_busy && !m_bad && !m_wait) abort = bus.soft_reset[m_port];
            m_perr = 0;
            m_drop = 0;
            if (abort) begin
                m_wen  = 0;
                m_lfd  = 0;
                m_bad  = 1;
                m_wait = 1;
                m_left = m_left - (acc ? 1 : 0);
            end else begin
                if (!hold) begin m_wen = 0; m_lfd = 0; end
                if (m_wait) begin
                    m_wait = 0;
                    if (m_left == 0) begin m_drop = 1; m_busy = 0; m_bad = 0; end
                end else if (acc) begin
                    if (!m_busy) begin
                        m_port = d[1:0];
                        m_left = int'(d[7:2]) + 1;
                        m_par  = d;
                        m_busy = 1;
                        if (d[1:0] == 2'd3) m_bad = 1;
                        else begin m_wen = 3'b001 << d[1:0]; m_dout = d; m_lfd = 1; end
                    end else if (m_bad) begin
                        m_left--;
                        if (m_left == 0) begin m_drop = 1; m_busy = 0; m_bad = 0; end
                    end else begin
                        m_wen  = 3'b001 << m_port;
                        m_dout = d;
                        m_lfd  = 0;
                        if (m_left == 1) m_perr = (d != m_par);
                        else m_par = m_par ^ d;
                        m_left--;
                        if (m_left == 0) m_busy = 0;
                    end
                end
            end
        end
    end

    // Cycle counters used by the directed scenarios.
    int n_w010, run, max_run, n_lfd, n_perr, n_drop, n_wany, n_cons, n_rlow;

    always @(negedge clk) begin
        if (!reset) begin
            check("ready", 32'(bus.ready), 32'(!m_wait && !(|(m_wen & bus.fifo_full))));
            check("write_enb", 32'(bus.write_enb), 32'(m_wen));
            check("lfd_state", 32'(bus.lfd_state), 32'(m_lfd));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("parity_err", 32'(bus.parity_err), 32'(m_perr));
            check("pkt_drop", 32'(bus.pkt_drop), 32'(m_drop));
            if (m_wen != 0) check("dout", 32'(bus.dout), 32'(m_dout));
            if (bus.write_enb == 3'b010) begin
                n_w010++; run++;
                if (run > max_run) max_run = run;
            end else run = 0;
            n_lfd  += int'(bus.lfd_state);
            n_perr += int'(bus.parity_err);
            n_drop += int'(bus.pkt_drop);
            if (|bus.write_enb) n_wany++;
            if (|(bus.write_enb & ~bus.fifo_full)) n_cons++;
            if (!bus.ready) n_rlow++;
        end
    end

    task automatic clr();
        n_w010 = 0; run = 0; max_run = 0; n_lfd = 0; n_perr = 0;
        n_drop = 0; n_wany = 0; n_cons = 0; n_rlow = 0;
    endtask

    logic       rand_en = 0;
    int         full_cnt = 0;
    logic [2:0] full_mask = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (full_cnt > 0) begin
            bus.fifo_full = full_mask;
            full_cnt--;
        end else begin
            bus.fifo_full = (rand_en && $urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
        end
        bus.soft_reset = (rand_en && $urandom_range(0, 60) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        logic acc;
        bus.pkt_valid = 1;
        bus.data_in   = b;
        g   = 0;
        acc = 0;
        while (!acc && g < 300) begin
            @(negedge clk);
            acc = bus.ready;
            tick();
            g++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par_flip,
                            input int stall_after, input int abort_after);
        logic [7:0] par, p;
        int n;
        n   = int'(hdr[7:2]);
        par = hdr;
        send_byte(hdr);
        for (int i = 0; i < n; i++) begin
            p   = 8'($urandom);
            par = par ^ p;
            send_byte(p);
            if (i + 1 == stall_after) begin
                full_mask     = 3'b001 << hdr[1:0];
                bus.fifo_full = full_mask;
                full_cnt      = 2;
            end
            if (i + 1 == abort_after) bus.soft_reset = 3'b001 << hdr[1:0];
        end
        send_byte(par ^ par_flip);
        bus.pkt_valid = 0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr;
        reset = 1;
        bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0; bus.soft_reset = 0;
        clr();
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_wen", 32'(bus.write_enb), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_lfd", 32'(bus.lfd_state), 0);
        check("rst_perr", 32'(bus.parity_err), 0);
        check("rst_drop", 32'(bus.pkt_drop), 0);
        tick();
        reset = 0;
        tick();

        // good packet, addr 1 len 14
        clr();
        send_pkt(8'h39, 8'h00, 0, 0);
        drain();
        check("good_writes", 32'(n_w010), 16);
        check("good_consecutive", 32'(max_run), 16);
        check("good_lfd", 32'(n_lfd), 1);
        check("good_perr", 32'(n_perr), 0);

        // same packet with a corrupted parity byte
        clr();
        send_pkt(8'h39, 8'h01, 0, 0);
        drain();
        check("badpar_writes", 32'(n_w010), 16);
        check("badpar_perr", 32'(n_perr), 1);

        // FIFO0 full for 3 cycles after the 2nd payload write
        clr();
        send_pkt(8'h10, 8'h00, 2, 0);
        drain();
        check("stall_consumed", 32'(n_cons), 6);
        check("stall_ready_low", 32'(n_rlow), 3);
        check("stall_wen_cycles", 32'(n_wany), 9);

        // invalid address 3, len 2
        clr();
        send_pkt(8'h0B, 8'h00, 0, 0);
        drain();
        check("badaddr_wen", 32'(n_wany), 0);
        check("badaddr_ready_low", 32'(n_rlow), 0);
        check("badaddr_drop", 32'(n_drop), 1);

        // abort on FIFO2 after payload byte 5 of 10, then a normal packet
        clr();
        send_pkt(8'h2A, 8'h00, 0, 5);
        drain();
        check("abort_consumed", 32'(n_cons), 6);
        check("abort_drop", 32'(n_drop), 1);
        check("abort_perr", 32'(n_perr), 0);
        clr();
        send_pkt(8'h0E, 8'h00, 0, 0);
        drain();
        check("post_abort_consumed", 32'(n_cons), 5);
        check("post_abort_drop", 32'(n_drop), 0);
        check("post_abort_lfd", 32'(n_lfd), 1);

        // randomized packets with random back-pressure and soft resets
        rand_en = 1;
        for (int k = 0; k < 300; k++) begin
            hdr[1:0] = 2'($urandom_range(0, 3));
            hdr[7:2] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
            send_pkt(hdr, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_en = 0;
        drain();
        @(negedge clk);
        check("final_busy", 32'(bus.busy), 0);
        check("final_wen", 32'(bus.write_enb), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
